// File: rtl/ext_pkg.sv
// Shared definitions for the extension pipeline: the operation encoding used
// by the decode stage and by the extension datapath.
package ext_pkg;

  typedef enum logic [2:0] {
    SEXT   = 3'd0,
    ZEXT   = 3'd1,
    UPPER  = 3'd2,
    BRANCH = 3'd3,
    LB     = 3'd4,
    LBU    = 3'd5,
    LH     = 3'd6,
    LHU    = 3'd7
  } ext_op_t;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate / load-data extender. It selects and extends the
// operand for one request and flags misaligned halfword loads.
module ext_core
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  localparam int BOFF_W = $clog2(DATA_W/8)
) (
  input  ext_op_t             i_op,
  input  logic [IMM_W-1:0]    i_imm,
  input  logic [DATA_W-1:0]   i_data,
  input  logic [BOFF_W-1:0]   i_boff,
  output logic [DATA_W-1:0]   o_data,
  output logic                o_err
);

  logic [BOFF_W-1:0] w_hOff;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_immSext;

  // Halfword lanes are addressed by the byte offset with its low bit dropped.
  assign w_hOff    = i_boff & ~BOFF_W'(1);
  assign w_byte    = i_data[{i_boff, 3'b000} +: 8];
  assign w_half    = i_data[{w_hOff, 3'b000} +: 16];
  assign w_immSext = {{(DATA_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};

  always_comb begin
    o_data = '0;
    o_err  = 1'b0;
    case (i_op)
      SEXT:   o_data = w_immSext;
      ZEXT:   o_data = {{(DATA_W-IMM_W){1'b0}}, i_imm};
      UPPER:  o_data = {i_imm, {(DATA_W-IMM_W){1'b0}}};
      BRANCH: o_data = w_immSext << 2;
      LB:     o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LBU:    o_data = {{(DATA_W-8){1'b0}}, w_byte};
      LH: begin
        if (i_boff[0]) o_err  = 1'b1;
        else           o_data = {{(DATA_W-16){w_half[15]}}, w_half};
      end
      LHU: begin
        if (i_boff[0]) o_err  = 1'b1;
        else           o_data = {{(DATA_W-16){1'b0}}, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined extension stage: valid/ready input, a 2-entry result FIFO and
// registered in_ready so consumer stalls never reach the producer combinationally.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  localparam int BOFF_W = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [DATA_W-1:0] in_data,
  input  logic [BOFF_W-1:0] in_boff,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  logic [DATA_W-1:0] r_data [2];
  logic              r_err  [2];
  logic              r_rdPtr;
  logic              r_wrPtr;
  logic [1:0]        r_count;

  logic [DATA_W-1:0] w_extData;
  logic              w_extErr;
  logic              w_push;
  logic              w_pop;

  ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_core (
    .i_op   (ext_op_t'(in_op)),
    .i_imm  (in_imm),
    .i_data (in_data),
    .i_boff (in_boff),
    .o_data (w_extData),
    .o_err  (w_extErr)
  );

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_data[r_rdPtr];
  assign out_err   = r_err[r_rdPtr];

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // Storage is cleared on reset so an empty buffer presents zeros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
        r_err[i]  <= 1'b0;
      end
      r_rdPtr <= 1'b0;
      r_wrPtr <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_data[r_wrPtr] <= w_extData;
        r_err[r_wrPtr]  <= w_extErr;
        r_wrPtr         <= ~r_wrPtr;
      end
      if (w_pop) r_rdPtr <= ~r_rdPtr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
